video_timing_gen: RTL and testbench

- Parametrised successor to the fixed 396x256 arcade H/V timing generator used by the arcade cores.
- Runs on the system clock with a pixel clock-enable instead of a derived pixel clock.
- Produces pixel coordinates for the game core, blanking and sync for arcade_video, and a blank-masked RGB pass-through.
- Adds the following beyond the fixed generator: any frame geometry, sync windows that wrap around the line or frame, tear-free offsets latched at frame boundary, and line/frame strobes.

---
 rtl/video_timing_gen.sv | 151 +++++++++++++++
 tb/tb_video_timing_gen.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/video_timing_gen.sv
// Parametrised arcade H/V timing generator on clk_sys with a pixel clock-enable.
// Optional interlace-style field output and alternating frame length under `VTG_FIELD_EN`.
module video_timing_gen #(
  parameter int H_TOTAL      = 396,
  parameter int H_ACT_START  = 25,
  parameter int H_ACT_END    = 265,
  parameter int H_SYNC_START = 320,
  parameter int H_SYNC_LEN   = 31,
  parameter int HPOS_SUB     = 24,
  parameter int V_TOTAL      = 256,
  parameter int V_ACT_END    = 224,
  parameter int V_SYNC_START = 226,
  parameter int V_SYNC_LEN   = 5,
  parameter int RGB_W        = 12,
  parameter int HOFF_W       = 5,
  parameter int VOFF_W       = 4,
  localparam int CW_H        = $clog2(H_TOTAL),
  localparam int CW_V        = $clog2(V_TOTAL + 1)
) (
  input  logic                     clk_sys,
  input  logic                     reset,
  input  logic                     ce_pix,
  input  logic signed [HOFF_W-1:0] hoffs,
  input  logic signed [VOFF_W-1:0] voffs,
  input  logic        [RGB_W-1:0]  rgb_in,
  output logic        [CW_H-1:0]   hpos,
  output logic        [CW_V-1:0]   vpos,
  output logic        [RGB_W-1:0]  rgb_out,
  output logic                     hblank,
  output logic                     vblank,
  output logic                     hsync,
  output logic                     vsync,
  output logic                     line_start,
`ifdef VTG_FIELD_EN
  output logic                     field,
`endif
  output logic                     frame_start
);

  logic [CW_H-1:0] hcnt_r, hs0_r, hs0_next_s;
  logic [CW_V-1:0] vcnt_r, vs0_r, vs0_next_s;
  logic [CW_H:0]   hd_s;
  logic [CW_V:0]   vd_s, v_len_s, v_len_next_s;
  logic            field_s, field_next_s;
  logic            h_last_s, v_last_s;
  logic            hblank_s, vblank_s, hsync_s, vsync_s;

  // Single-step modulo reduction; offsets are always much smaller than the totals.
  function automatic int wrap_mod(input int s, input int m);
    int r;
    if (s < 0) begin
      r = s + m;
    end else if (s >= m) begin
      r = s - m;
    end else begin
      r = s;
    end
    return r;
  endfunction

`ifdef VTG_FIELD_EN
  logic field_r;

  // Field flips at every frame wrap; odd fields carry one extra blanked line.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      field_r <= 1'b0;
    end else if (ce_pix && h_last_s && v_last_s) begin
      field_r <= ~field_r;
    end else begin
      field_r <= field_r;
    end
  end

  assign field        = field_r;
  assign field_s      = field_r;
  assign field_next_s = ~field_r;
`else
  assign field_s      = 1'b0;
  assign field_next_s = 1'b0;
`endif

  assign hpos = hcnt_r - CW_H'(HPOS_SUB);
  assign vpos = vcnt_r;

  // Wrap detection, per-frame sync starts and distance-into-window compares.
  always_comb begin
    v_len_s      = field_s ? (CW_V+1)'(V_TOTAL + 1) : (CW_V+1)'(V_TOTAL);
    v_len_next_s = field_next_s ? (CW_V+1)'(V_TOTAL + 1) : (CW_V+1)'(V_TOTAL);
    h_last_s     = (hcnt_r == CW_H'(H_TOTAL - 1));
    v_last_s     = ({1'b0, vcnt_r} == (v_len_s - (CW_V+1)'(1)));
    hs0_next_s   = CW_H'(wrap_mod(H_SYNC_START + int'(hoffs), H_TOTAL));
    vs0_next_s   = CW_V'(wrap_mod(V_SYNC_START + int'(voffs), int'(v_len_next_s)));
    if (hcnt_r >= hs0_r) begin
      hd_s = {1'b0, hcnt_r} - {1'b0, hs0_r};
    end else begin
      hd_s = {1'b0, hcnt_r} + (CW_H+1)'(H_TOTAL) - {1'b0, hs0_r};
    end
    if (vcnt_r >= vs0_r) begin
      vd_s = {1'b0, vcnt_r} - {1'b0, vs0_r};
    end else begin
      vd_s = {1'b0, vcnt_r} + v_len_s - {1'b0, vs0_r};
    end
    hsync_s  = (hd_s < (CW_H+1)'(H_SYNC_LEN));
    vsync_s  = (vd_s < (CW_V+1)'(V_SYNC_LEN));
    hblank_s = (hcnt_r < CW_H'(H_ACT_START)) || (hcnt_r >= CW_H'(H_ACT_END));
    vblank_s = (vcnt_r >= CW_V'(V_ACT_END));
  end

  // Counters, frame-boundary offset latch, registered video outputs and strobes.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      hcnt_r      <= {CW_H{1'b0}};
      vcnt_r      <= {CW_V{1'b0}};
      hs0_r       <= CW_H'(wrap_mod(H_SYNC_START, H_TOTAL));
      vs0_r       <= CW_V'(wrap_mod(V_SYNC_START, V_TOTAL));
      hblank      <= 1'b1;
      vblank      <= 1'b1;
      hsync       <= 1'b0;
      vsync       <= 1'b0;
      rgb_out     <= {RGB_W{1'b0}};
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      if (ce_pix) begin
        hblank  <= hblank_s;
        vblank  <= vblank_s;
        hsync   <= hsync_s;
        vsync   <= vsync_s;
        rgb_out <= (hblank || vblank) ? {RGB_W{1'b0}} : rgb_in;
        if (h_last_s) begin
          hcnt_r     <= {CW_H{1'b0}};
          line_start <= 1'b1;
          if (v_last_s) begin
            vcnt_r      <= {CW_V{1'b0}};
            frame_start <= 1'b1;
            hs0_r       <= hs0_next_s;
            vs0_r       <= vs0_next_s;
          end else begin
            vcnt_r <= vcnt_r + CW_V'(1);
          end
        end else begin
          hcnt_r <= hcnt_r + CW_H'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench for video_timing_gen: default geometry, wrapped sync windows,
// frame-boundary offset latching on a short-frame instance, and mid-line reset.
module tb_video_timing_gen;

  logic clk_sys = 1'b0;
  logic reset   = 1'b1;
  logic ce_pix  = 1'b1;
  logic [11:0] rgb_in = 12'hFFF;

  logic signed [4:0] hoffs_def = 5'sd0, hoffs_cs = 5'sd0, hoffs_sm = 5'sd0, hoffs_wr = 5'sd10;
  logic signed [3:0] voffs_z = 4'sd0, voffs_sm = 4'sd0;

  logic [8:0]  def_hpos, cs_hpos, sm_hpos, wr_hpos;
  logic [8:0]  def_vpos, cs_vpos;
  logic [3:0]  sm_vpos;
  logic [2:0]  wr_vpos;
  logic [11:0] def_rgb, cs_rgb, sm_rgb, wr_rgb;
  logic def_hb, def_vb, def_hs, def_vs, def_ls, def_fs;
  logic cs_hb, cs_vb, cs_hs, cs_vs, cs_ls, cs_fs;
  logic sm_hb, sm_vb, sm_hs, sm_vs, sm_ls, sm_fs;
  logic wr_hb, wr_vb, wr_hs, wr_vs, wr_ls, wr_fs;
`ifdef VTG_FIELD_EN
  logic def_fld, cs_fld, sm_fld, wr_fld;
`endif

  int n_assert = 0;
  int n_fail   = 0;
  int k        = 0;

  always #5 clk_sys = ~clk_sys;

  video_timing_gen u_def (
    .clk_sys(clk_sys), .reset(reset), .ce_pix(ce_pix), .hoffs(hoffs_def), .voffs(voffs_z),
    .rgb_in(rgb_in), .hpos(def_hpos), .vpos(def_vpos), .rgb_out(def_rgb), .hblank(def_hb),
    .vblank(def_vb), .hsync(def_hs), .vsync(def_vs), .line_start(def_ls),
`ifdef VTG_FIELD_EN
    .field(def_fld),
`endif
    .frame_start(def_fs));

  video_timing_gen #(.H_SYNC_START(380)) u_cs (
    .clk_sys(clk_sys), .reset(reset), .ce_pix(ce_pix), .hoffs(hoffs_cs), .voffs(voffs_z),
    .rgb_in(rgb_in), .hpos(cs_hpos), .vpos(cs_vpos), .rgb_out(cs_rgb), .hblank(cs_hb),
    .vblank(cs_vb), .hsync(cs_hs), .vsync(cs_vs), .line_start(cs_ls),
`ifdef VTG_FIELD_EN
    .field(cs_fld),
`endif
    .frame_start(cs_fs));

  video_timing_gen #(.V_TOTAL(8), .V_ACT_END(6), .V_SYNC_START(6), .V_SYNC_LEN(2)) u_sm (
    .clk_sys(clk_sys), .reset(reset), .ce_pix(ce_pix), .hoffs(hoffs_sm), .voffs(voffs_sm),
    .rgb_in(rgb_in), .hpos(sm_hpos), .vpos(sm_vpos), .rgb_out(sm_rgb), .hblank(sm_hb),
    .vblank(sm_vb), .hsync(sm_hs), .vsync(sm_vs), .line_start(sm_ls),
`ifdef VTG_FIELD_EN
    .field(sm_fld),
`endif
    .frame_start(sm_fs));

  video_timing_gen #(.H_SYNC_START(390), .V_TOTAL(4), .V_ACT_END(3), .V_SYNC_START(3),
                     .V_SYNC_LEN(1)) u_wr (
    .clk_sys(clk_sys), .reset(reset), .ce_pix(ce_pix), .hoffs(hoffs_wr), .voffs(voffs_z),
    .rgb_in(rgb_in), .hpos(wr_hpos), .vpos(wr_vpos), .rgb_out(wr_rgb), .hblank(wr_hb),
    .vblank(wr_vb), .hsync(wr_hs), .vsync(wr_vs), .line_start(wr_ls),
`ifdef VTG_FIELD_EN
    .field(wr_fld),
`endif
    .frame_start(wr_fs));

  task automatic check(input string tag, input int j, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s at ce %0d: observed %0h expected %0h", tag, j, obs, exp);
    end
  endtask

  function automatic logic [8:0] hpos_after(input int j);
    int hn;
    hn = ((j % 396) + 1) % 396;
    return 9'(hn + 488);
  endfunction

  // Expected outputs after ce number j (j counted from the last reset release).
  task automatic check_ce(input int j);
    int hd, vd, vs, fs, fw;
    hd = j % 396;
    vd = j / 396;
    vs = vd % 8;
    fs = j / 3168;
    fw = j / 1584;
    check("def.hblank", j, 32'(def_hb), 32'((hd < 25) || (hd >= 265)));
    check("def.vblank", j, 32'(def_vb), 32'(vd >= 224));
    check("def.hsync",  j, 32'(def_hs), 32'((hd >= 320) && (hd <= 350)));
    check("def.vsync",  j, 32'(def_vs), 32'((vd >= 226) && (vd <= 230)));
    check("def.rgb",    j, 32'(def_rgb), ((hd >= 26) && (hd <= 265)) ? 32'h0000_0FFF : 32'h0);
    check("def.hpos",   j, 32'(def_hpos), 32'(hpos_after(j)));
    check("def.vpos",   j, 32'(def_vpos), 32'((j + 1) / 396));
    check("def.line_start",  j, 32'(def_ls), 32'(hd == 395));
    check("def.frame_start", j, 32'(def_fs), 32'((hd == 395) && (vd == 255)));
    check("cs.hsync",   j, 32'(cs_hs), 32'((hd >= 380) || (hd < 15)));
    check("sm.hsync",   j, 32'(sm_hs),
          (fs == 0) ? 32'((hd >= 320) && (hd <= 350)) : 32'((hd >= 304) && (hd <= 334)));
    check("sm.vsync",   j, 32'(sm_vs),
          (fs == 0) ? 32'((vs == 6) || (vs == 7)) : 32'((vs == 5) || (vs == 6)));
    check("sm.vblank",  j, 32'(sm_vb), 32'(vs >= 6));
    check("sm.vpos",    j, 32'(sm_vpos), 32'(((j + 1) / 396) % 8));
    check("sm.frame_start", j, 32'(sm_fs), 32'((hd == 395) && (vs == 7)));
    check("wr.hsync",   j, 32'(wr_hs),
          (fw == 0) ? 32'((hd >= 390) || (hd < 25)) : 32'((hd >= 4) && (hd <= 34)));
  endtask

  task automatic step(input int gap, input bit chk);
    for (int i = 0; i < gap; i++) begin
      ce_pix = 1'b0;
      @(posedge clk_sys);
      #1;
      if (chk && (k > 0)) begin
        check("idle.line_start",  k, 32'(def_ls), 32'h0);
        check("idle.frame_start", k, 32'(sm_fs), 32'h0);
        check("idle.hpos_hold",   k, 32'(def_hpos), 32'(hpos_after(k - 1)));
      end
    end
    ce_pix = 1'b1;
    @(posedge clk_sys);
    #1;
    ce_pix = 1'b0;
    if (chk) check_ce(k);
    k++;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, ".hpos"},   k, 32'(def_hpos), 32'd488);
    check({tag, ".vpos"},   k, 32'(def_vpos), 32'd0);
    check({tag, ".hblank"}, k, 32'(def_hb), 32'd1);
    check({tag, ".vblank"}, k, 32'(def_vb), 32'd1);
    check({tag, ".hsync"},  k, 32'(def_hs), 32'd0);
    check({tag, ".vsync"},  k, 32'(def_vs), 32'd0);
    check({tag, ".rgb"},    k, 32'(def_rgb), 32'd0);
    check({tag, ".line_start"},  k, 32'(def_ls), 32'd0);
    check({tag, ".frame_start"}, k, 32'(def_fs), 32'd0);
    check({tag, ".sm_frame_start"}, k, 32'(sm_fs), 32'd0);
    check({tag, ".sm_vpos"}, k, 32'(sm_vpos), 32'd0);
  endtask

  initial begin
    // Reset held with ce_pix active.
    repeat (2) @(posedge clk_sys);
    #1;
    check_reset_state("rst0");
    reset  = 1'b0;
    ce_pix = 1'b0;

    // First line with ce_pix every 8th clock.
    for (int n = 0; n < 396; n++) step(7, 1'b1);

    // Offsets written mid-frame 0; they take effect from frame 1 only.
    hoffs_sm = -5'sd16;
    voffs_sm = -4'sd1;
    while (k < 6732) step(0, 1'b1);

    // Fast-forward so the next ce would be hcnt=200, vcnt=100.
    while (k < 39800) step(0, 1'b0);
    check("pre_rst.hpos", k, 32'(def_hpos), 32'd176);
    check("pre_rst.vpos", k, 32'(def_vpos), 32'd100);

    // Reset takes priority over a simultaneous ce_pix.
    reset  = 1'b1;
    ce_pix = 1'b1;
    @(posedge clk_sys);
    #1;
    k = 0;
    check_reset_state("rst1");
    reset  = 1'b0;
    ce_pix = 1'b0;
    for (int n = 0; n < 800; n++) step(0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
